sti_dac: RTL and testbench
==========================

STI_DAC -- requirements
Module: sti_dac

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 load  input  1  one-cycle request to accept a new parallel word.
REQ-005 pi_data  input  16  parallel data word.
REQ-006 pi_length  input  2  serial word length: 0=8, 1=16, 2=24, 3=32 bits.
REQ-007 pi_fill  input  1  zero-pad placement for 24/32-bit lengths.
REQ-008 pi_msb  input  1  bit order: 1=MSB first, 0=LSB first.
REQ-009 pi_low  input  1  byte select for 8-bit length: 1=pi_data[15:8], 0=pi_data[7:0].
REQ-010 pi_end  input  1  the last word has been loaded; level signal that stays high once set.
REQ-011 so_data  output  1  serial data bit.
REQ-012 so_valid  output  1  so_data is valid in this cycle.
REQ-013 oem_addr  output  5  memory word address.
REQ-014 oem_dataout  output  8  memory write data.
REQ-015 odd1_wr..odd4_wr, even1_wr..even4_wr  output  1 each  write strobes for eight 32x8 memories.
REQ-016 oem_finish  output  1  all 256 pixels have been written.

Function
REQ-017 load SHALL be sampled only in IDLE; load while busy SHALL be ignored.
REQ-018 On load, the block SHALL latch pi_data, pi_length, pi_fill, pi_msb and pi_low, and form word W of length L:
- L=8: W = pi_low ? pi_data[15:8] : pi_data[7:0].
- L=16: W = pi_data.
- L=24: W = pi_fill ? {pi_data,8'h00} : {8'h00,pi_data}.
- L=32: W = pi_fill ? {pi_data,16'h0000} : {16'h0000,pi_data}.
REQ-019 so_valid SHALL rise in the cycle after the load edge and stay high for exactly L consecutive cycles, presenting one bit per cycle.
REQ-020 The bits SHALL go out as W[L-1] down to W[0] if pi_msb=1, and as W[0] up to W[L-1] otherwise.
REQ-021 so_valid SHALL drop for at least one cycle between words; so_data SHALL be 0 whenever so_valid=0.
REQ-022 After a word completes, the block SHALL return to IDLE if pi_end=0, and enter PAD if pi_end=1.
REQ-023 Every 8 serial bits, in transmit order, SHALL form one pixel; the first transmitted bit is pixel bit 7.
REQ-024 Pixel counter p (8 bits, starts at 0) SHALL advance once per completed pixel.
REQ-025 Pixel p SHALL be stored as follows:
- bank = p[7:6] selects memory 1..4;
- oem_addr = p[5:1];
- odd memory if p[0]==p[4], even memory otherwise (checkerboard over a 16x16 image).
REQ-026 For each pixel write, oem_addr and oem_dataout SHALL be stable for one cycle before the selected strobe rises and while it is high.
REQ-027 Each strobe SHALL be a one-cycle pulse; at most one strobe SHALL be high at a time.
REQ-028 PAD SHALL write pixel value 8'h00 at every remaining p through 255, one write per 2 cycles or faster.
REQ-029 After the write at p=255 completes, oem_finish SHALL assert and hold until reset.
REQ-030 If exactly 256 pixels arrive via serial data, the block SHALL skip PAD and assert oem_finish.
REQ-031 State machine: IDLE -> (load) SHIFT -> (L bits done) IDLE or PAD -> (p wrapped) DONE; DONE is terminal.

Reset
REQ-032 While reset=0, all outputs SHALL be 0 and the bit counter, pixel counter, shift register and FSM (to IDLE) SHALL clear.
REQ-033 A reset asserted mid-word or mid-PAD SHALL abort the operation immediately, with no further strobes.

Structure
REQ-034 A shared package SHALL hold the length codes (LEN8/16/24/32), the FSM state enum, PIXELS=256 and MEM_DEPTH=32.
REQ-035 The pixel packer and memory writer SHALL be one sub-module, sti_dac_oem_writer, fed by so_data and so_valid.

Verification
REQ-036 len=0, low=1, msb=1, data=16'hA5C3 -> so = 1,0,1,0,0,1,0,1 over 8 valid cycles; odd1[0]=8'hA5.
REQ-037 len=1, msb=0, data=16'h0001 -> 16 valid cycles, first bit 1 followed by 15 zeros.
REQ-038 len=3, fill=1, msb=1, data=16'h8001 -> 32 bits: 1, fourteen 0s, 1, sixteen 0s.
REQ-039 len=2, fill=0, msb=1, data=16'hFFFF -> eight 0s then sixteen 1s.
REQ-040 Two 8-bit words 8'h11 and 8'h22, pi_end set with the second -> odd1[0]=11, even1[0]=22, all other 254 cells 00, oem_finish high and held; pixel 16 lands in even1[8].
REQ-041 Reset low mid-way through a 32-bit word -> so_valid=0 immediately, all strobes 0; the next load restarts cleanly at p=0.

Source files
------------

// File: rtl/sti_dac_pkg.sv
// -----------------------------------------------------------------------------
// sti_dac_pkg
// Shared definitions for the serial transmitter / image memory writer.
//   - len_e   : serial word length codes (8/16/24/32 bits)
//   - state_e : controller states
//   - PIXELS, MEM_DEPTH and derived counter/address widths
//   - form_word / len_bits : word assembly helpers used at load time
// -----------------------------------------------------------------------------
package sti_dac_pkg;

  typedef enum logic [1:0] {
    LEN8  = 2'd0,
    LEN16 = 2'd1,
    LEN24 = 2'd2,
    LEN32 = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAD   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int PIXELS    = 256;
  localparam int MEM_DEPTH = 32;
  localparam int PIX_W     = $clog2(PIXELS);
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  // Number of serial bits for a length code.
  function automatic logic [5:0] len_bits(input logic [1:0] len);
    logic [5:0] n;
    unique case (len_e'(len))
      LEN8:    n = 6'd8;
      LEN16:   n = 6'd16;
      LEN24:   n = 6'd24;
      LEN32:   n = 6'd32;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

  // Serial word, right-aligned in 32 bits (bit L-1 is the word MSB).
  function automatic logic [31:0] form_word(input logic [15:0] d,
                                            input logic [1:0]  len,
                                            input logic        fill,
                                            input logic        low);
    logic [31:0] w;
    unique case (len_e'(len))
      LEN8:    w = {24'h0, (low ? d[15:8] : d[7:0])};
      LEN16:   w = {16'h0, d};
      LEN24:   w = fill ? {8'h0, d, 8'h00} : {16'h0, d};
      LEN32:   w = fill ? {d, 16'h0000} : {16'h0000, d};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sti_dac_oem_writer.sv
// -----------------------------------------------------------------------------
// sti_dac_oem_writer
// Packs the serial stream into 8-bit pixels (first bit = pixel bit 7) and
// writes each pixel into one of eight 32x8 memories laid out as a 16x16
// checkerboard. When pad_en is high it fills the remaining pixels with 0.
// Ports:
//   clk, reset        clock, async active-low reset
//   so_data, so_valid serial stream from the transmitter
//   pad_en            request zero-fill of remaining pixels
//   oem_addr          memory word address (p[5:1])
//   oem_dataout       memory write data
//   odd_wr, even_wr   one-hot write strobes, index = bank p[7:6]
//   oem_finish        all pixels written; sticky until reset
// -----------------------------------------------------------------------------
module sti_dac_oem_writer
  import sti_dac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              so_data,
  input  logic              so_valid,
  input  logic              pad_en,
  output logic [ADDR_W-1:0] oem_addr,
  output logic [7:0]        oem_dataout,
  output logic [3:0]        odd_wr,
  output logic [3:0]        even_wr,
  output logic              oem_finish
);

  logic [7:0]        pix_q,  pix_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [PIX_W-1:0]  p_q,    p_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              arm_q,  arm_d;
  logic              wrap_q, wrap_d;
  logic              fin_q,  fin_d;
  logic [3:0]        odd_q,  odd_d;
  logic [3:0]        even_q, even_d;
  logic              pix_done;
  logic              can_arm;

  // A write is two cycles: "arm" presents addr/data, the next cycle raises
  // the strobe with addr/data unchanged. Serial pixels are >= 8 cycles apart,
  // so a serial pixel never collides with an armed write.
  always_comb begin
    pix_d    = pix_q;
    bcnt_d   = bcnt_q;
    p_d      = p_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    arm_d    = 1'b0;
    wrap_d   = wrap_q;
    fin_d    = fin_q | wrap_q;
    odd_d    = 4'h0;
    even_d   = 4'h0;
    pix_done = so_valid && (bcnt_q == 3'd7);
    can_arm  = !arm_q && !wrap_q && !fin_q;

    if (so_valid) begin
      pix_d  = {pix_q[6:0], so_data};
      bcnt_d = bcnt_q + 3'd1;
    end

    if (can_arm && (pix_done || pad_en)) begin
      arm_d  = 1'b1;
      addr_d = p_q[5:1];
      dout_d = pix_done ? {pix_q[6:0], so_data} : 8'h00;
    end

    if (arm_q) begin
      // Checkerboard: odd memory when column parity matches row parity.
      if (p_q[0] == p_q[4]) odd_d[p_q[7:6]]  = 1'b1;
      else                  even_d[p_q[7:6]] = 1'b1;
      p_d = p_q + 1'b1;
      if (p_q == PIX_W'(PIXELS - 1)) wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q  <= '0;
      bcnt_q <= '0;
      p_q    <= '0;
      addr_q <= '0;
      dout_q <= '0;
      arm_q  <= 1'b0;
      wrap_q <= 1'b0;
      fin_q  <= 1'b0;
      odd_q  <= '0;
      even_q <= '0;
    end else begin
      pix_q  <= pix_d;
      bcnt_q <= bcnt_d;
      p_q    <= p_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      arm_q  <= arm_d;
      wrap_q <= wrap_d;
      fin_q  <= fin_d;
      odd_q  <= odd_d;
      even_q <= even_d;
    end
  end

  assign oem_addr    = addr_q;
  assign oem_dataout = dout_q;
  assign odd_wr      = odd_q;
  assign even_wr     = even_q;
  assign oem_finish  = fin_q;

endmodule

// File: rtl/sti_dac.sv
// -----------------------------------------------------------------------------
// sti_dac
// Loads a 16-bit parallel word, expands it to an 8/16/24/32-bit serial word
// and shifts it out one bit per cycle (MSB or LSB first). The serial stream
// is packed into pixels and written to eight 32x8 image memories; after the
// last word the remaining pixels are zero-filled.
// Ports:
//   clk, reset                 clock, async active-low reset
//   load                       accept parallel word (honoured in IDLE only)
//   pi_data/length/fill/msb/low  word content and format
//   pi_end                     last word loaded (level)
//   so_data, so_valid          serial output
//   oem_addr, oem_dataout      memory address / write data
//   odd1..4_wr, even1..4_wr    memory write strobes
//   oem_finish                 all 256 pixels written
// -----------------------------------------------------------------------------
module sti_dac
  import sti_dac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] pi_data,
  input  logic [1:0]  pi_length,
  input  logic        pi_fill,
  input  logic        pi_msb,
  input  logic        pi_low,
  input  logic        pi_end,
  output logic        so_data,
  output logic        so_valid,
  output logic [4:0]  oem_addr,
  output logic [7:0]  oem_dataout,
  output logic        odd1_wr,
  output logic        odd2_wr,
  output logic        odd3_wr,
  output logic        odd4_wr,
  output logic        even1_wr,
  output logic        even2_wr,
  output logic        even3_wr,
  output logic        even4_wr,
  output logic        oem_finish
);

  state_e      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        msb_q, msb_d;
  logic        so_valid_q, so_valid_d;
  logic        so_data_q, so_data_d;
  logic [5:0]  len_l;
  logic [31:0] w_raw, w_al;
  logic [3:0]  odd_wr, even_wr;
  logic        finish;

  // MSB-first words are left-justified so the outgoing bit is always sr[31];
  // LSB-first words stay right-aligned and go out from sr[0]. The first bit
  // is emitted on the load edge, so cnt holds the bits still to send.
  always_comb begin
    len_l      = len_bits(pi_length);
    w_raw      = form_word(pi_data, pi_length, pi_fill, pi_low);
    w_al       = pi_msb ? (w_raw << (6'd32 - len_l)) : w_raw;
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    msb_d      = msb_q;
    so_valid_d = 1'b0;
    so_data_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (finish) begin
          state_d = S_DONE;
        end else if (load) begin
          msb_d      = pi_msb;
          so_valid_d = 1'b1;
          so_data_d  = pi_msb ? w_al[31] : w_al[0];
          sr_d       = pi_msb ? (w_al << 1) : (w_al >> 1);
          cnt_d      = len_l - 6'd1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != 6'd0) begin
          so_valid_d = 1'b1;
          so_data_d  = msb_q ? sr_q[31] : sr_q[0];
          sr_d       = msb_q ? (sr_q << 1) : (sr_q >> 1);
          cnt_d      = cnt_q - 6'd1;
        end else begin
          state_d = pi_end ? S_PAD : S_IDLE;
        end
      end
      S_PAD: begin
        if (finish) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      msb_q      <= 1'b0;
      so_valid_q <= 1'b0;
      so_data_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      msb_q      <= msb_d;
      so_valid_q <= so_valid_d;
      so_data_q  <= so_data_d;
    end
  end

  sti_dac_oem_writer u_writer (
    .clk         (clk),
    .reset       (reset),
    .so_data     (so_data_q),
    .so_valid    (so_valid_q),
    .pad_en      (state_q == S_PAD),
    .oem_addr    (oem_addr),
    .oem_dataout (oem_dataout),
    .odd_wr      (odd_wr),
    .even_wr     (even_wr),
    .oem_finish  (finish)
  );

  assign so_data    = so_data_q;
  assign so_valid   = so_valid_q;
  assign oem_finish = finish;
  assign odd1_wr    = odd_wr[0];
  assign odd2_wr    = odd_wr[1];
  assign odd3_wr    = odd_wr[2];
  assign odd4_wr    = odd_wr[3];
  assign even1_wr   = even_wr[0];
  assign even2_wr   = even_wr[1];
  assign even3_wr   = even_wr[2];
  assign even4_wr   = even_wr[3];

endmodule

// File: tb/tb_sti_dac.sv
// -----------------------------------------------------------------------------
// tb_sti_dac
// Directed bench for sti_dac: serial bit patterns for each length/order
// option, memory placement, mid-word reset, zero-fill and finish.
// -----------------------------------------------------------------------------
module tb_sti_dac;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end;
  logic        so_data, so_valid;
  logic [4:0]  oem_addr;
  logic [7:0]  oem_dataout;
  logic        odd1_wr, odd2_wr, odd3_wr, odd4_wr;
  logic        even1_wr, even2_wr, even3_wr, even4_wr;
  logic        oem_finish;

  int errors = 0;
  int checks = 0;

  // Memory model: index 0..3 = odd1..odd4, 4..7 = even1..even4.
  logic [7:0] mem [8][32];
  logic       clr_req = 1'b0;
  int         wr_cnt = 0;
  int         multi_cnt = 0;
  int         unstable_cnt = 0;
  int         rst_strb = 0;
  logic [4:0] prev_addr = '0;
  logic [7:0] prev_dout = '0;

  always #5 clk = ~clk;

  sti_dac dut (
    .clk(clk), .reset(reset), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .so_data(so_data), .so_valid(so_valid),
    .oem_addr(oem_addr), .oem_dataout(oem_dataout),
    .odd1_wr(odd1_wr), .odd2_wr(odd2_wr), .odd3_wr(odd3_wr), .odd4_wr(odd4_wr),
    .even1_wr(even1_wr), .even2_wr(even2_wr), .even3_wr(even3_wr),
    .even4_wr(even4_wr), .oem_finish(oem_finish)
  );

  always @(negedge clk) begin
    logic [7:0] strb;
    strb = {even4_wr, even3_wr, even2_wr, even1_wr,
            odd4_wr, odd3_wr, odd2_wr, odd1_wr};
    if (!reset && strb != 8'h00) rst_strb++;
    if (clr_req) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 32; j++) mem[i][j] = 8'hEE;
      wr_cnt = 0;
    end else begin
      if ($countones(strb) > 1) multi_cnt++;
      if (strb != 8'h00) begin
        if (oem_addr !== prev_addr || oem_dataout !== prev_dout) unstable_cnt++;
        wr_cnt++;
        for (int i = 0; i < 8; i++)
          if (strb[i]) mem[i][oem_addr] = oem_dataout;
      end
    end
    prev_addr = oem_addr;
    prev_dout = oem_dataout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one load and capture the serial word; first bit lands in cap[nb-1].
  task automatic send_word(input string tag, input logic [1:0] len,
                           input logic [15:0] d, input logic fill,
                           input logic msb, input logic low, input logic endf,
                           output int nb, output logic [31:0] cap);
    int guard;
    load = 1'b1; pi_data = d; pi_length = len; pi_fill = fill;
    pi_msb = msb; pi_low = low; pi_end = endf;
    @(negedge clk);
    load = 1'b0;
    check({tag, "_lat"}, {31'h0, so_valid}, 32'h1);
    nb = 0; cap = '0; guard = 0;
    while (so_valid === 1'b1 && guard < 40) begin
      cap = {cap[30:0], so_data};
      nb++; guard++;
      @(negedge clk);
    end
    check({tag, "_gap_data"}, {31'h0, so_data}, 32'h0);
  endtask

  initial begin
    int          nb;
    logic [31:0] cap;
    int          bad;
    int          guard;
    int          snap;

    reset = 1'b0; load = 1'b0; pi_data = '0; pi_length = '0;
    pi_fill = 1'b0; pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    clr_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 clr_req = 1'b0;

    // Reset state
    check("rst_so", {30'h0, so_valid, so_data}, 32'h0);
    check("rst_mem_if", {19'h0, oem_addr, oem_dataout}, 32'h0);
    check("rst_strb", {24'h0, even4_wr, even3_wr, even2_wr, even1_wr,
                       odd4_wr, odd3_wr, odd2_wr, odd1_wr}, 32'h0);
    check("rst_finish", {31'h0, oem_finish}, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 8-bit, high byte, MSB first: A5 -> pixel 0 (odd1[0])
    send_word("w8", 2'd0, 16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b0, nb, cap);
    check("w8_len", nb, 32'd8);
    check("w8_bits", cap, 32'h0000_00A5);

    // 16-bit, LSB first: 1 then fifteen 0s -> pixels 80,00 at p=1,2
    send_word("w16", 2'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, nb, cap);
    check("w16_len", nb, 32'd16);
    check("w16_bits", cap, 32'h0000_8000);

    // 32-bit, fill=1, MSB first -> pixels 80,01,00,00 at p=3..6
    send_word("w32", 2'd3, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0, nb, cap);
    check("w32_len", nb, 32'd32);
    check("w32_bits", cap, 32'h8001_0000);

    // 24-bit, fill=0, MSB first -> pixels 00,FF,FF at p=7..9
    send_word("w24", 2'd2, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, nb, cap);
    check("w24_len", nb, 32'd24);
    check("w24_bits", cap, 32'h00_00FFFF);

    repeat (3) @(negedge clk);
    check("mem_odd1_0", {24'h0, mem[0][0]}, 32'hA5);
    check("mem_even1_0", {24'h0, mem[4][0]}, 32'h80);
    check("mem_even1_1", {24'h0, mem[4][1]}, 32'h80);
    check("mem_odd1_2", {24'h0, mem[0][2]}, 32'h01);
    check("mem_odd1_4", {24'h0, mem[0][4]}, 32'hFF);
    check("mem_even1_4", {24'h0, mem[4][4]}, 32'hFF);
    check("wr_cnt_10", wr_cnt, 32'd10);

    // Reset in the middle of a 32-bit word
    load = 1'b1; pi_data = 16'h1234; pi_length = 2'd3; pi_fill = 1'b0;
    pi_msb = 1'b1; pi_low = 1'b0; pi_end = 1'b0;
    @(negedge clk);
    load = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_valid_pre", {31'h0, so_valid}, 32'h1);
    #1 reset = 1'b0;
    #1;
    check("mid_valid", {31'h0, so_valid}, 32'h0);
    check("mid_strb", {24'h0, even4_wr, even3_wr, even2_wr, even1_wr,
                       odd4_wr, odd3_wr, odd2_wr, odd1_wr}, 32'h0);
    clr_req = 1'b1;
    @(negedge clk);
    #1 clr_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Two 8-bit words, pi_end with the second, then zero-fill to the end
    send_word("e1", 2'd0, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, nb, cap);
    check("e1_bits", cap, 32'h11);
    send_word("e2", 2'd0, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b1, nb, cap);
    check("e2_bits", cap, 32'h22);

    guard = 0;
    while (oem_finish !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("finish_seen", {31'h0, oem_finish}, 32'h1);
    repeat (2) @(negedge clk);

    check("odd1_0", {24'h0, mem[0][0]}, 32'h11);
    check("even1_0", {24'h0, mem[4][0]}, 32'h22);
    check("even1_8", {24'h0, mem[4][8]}, 32'h00);
    bad = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 32; j++)
        if (!((i == 0 && j == 0) || (i == 4 && j == 0)) && mem[i][j] !== 8'h00) bad++;
    check("other_cells_zero", bad, 32'd0);
    check("wr_cnt_256", wr_cnt, 32'd256);
    check("one_hot_strb", multi_cnt, 32'd0);
    check("addr_data_stable", unstable_cnt, 32'd0);
    check("no_strb_in_reset", rst_strb, 32'd0);

    // Finish holds, no further writes, loads ignored once done
    snap = wr_cnt;
    repeat (20) @(negedge clk);
    check("finish_held", {31'h0, oem_finish}, 32'h1);
    check("no_extra_wr", wr_cnt, snap);
    load = 1'b1; pi_length = 2'd0; pi_data = 16'h00FF;
    @(negedge clk);
    load = 1'b0;
    check("done_load_ignored", {31'h0, so_valid}, 32'h0);
    @(negedge clk);
    check("done_load_ignored2", {31'h0, so_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
